// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
//   Instruction fetch stage: owns the fetch PC, issues word-aligned reads to
//   instruction memory and fills the IF/ID pipeline register.
//   Handles hazard stalls, IF/ID flushes and branch/jump redirects. A redirect
//   can arrive while a read is still outstanding; the stage then waits for that
//   read to complete and throws its data away (DISCARD).
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   stall               hold PC and IF/ID
//   flush               force IF/ID to a bubble
//   branch_taken/target branch redirect from ID
//   jump/jump_target    jump redirect from ID (wins over branch)
//   imem_req/addr       instruction memory read request and address
//   imem_ready/rdata    read data valid for imem_addr this cycle
//   pc                  current fetch PC
//   if_id_*             IF/ID register: instruction, PC+4, valid
// -----------------------------------------------------------------------------
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid
);

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        imem_req_q, imem_req_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic [31:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
    logic        if_id_valid_q, if_id_valid_d;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic [31:0] discard_pc;

    assign redirect = jump | branch_taken;
    assign target   = (jump ? jump_target : branch_target) & 32'hFFFF_FFFC;
    assign pc_plus4 = pc_q + 32'd4;
    // While discarding, a fresh redirect replaces the saved one.
    assign discard_pc = redirect ? target : redirect_pc_q;

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        redirect_pc_d    = redirect_pc_q;
        if_id_instr_d    = if_id_instr_q;
        if_id_pc_plus4_d = if_id_pc_plus4_q;
        if_id_valid_d    = if_id_valid_q;
        logic_bubble : begin end

        case (state_q)
            BOOT: begin
                state_d          = FETCH;
                if_id_instr_d    = 32'd0;
                if_id_pc_plus4_d = 32'd0;
                if_id_valid_d    = 1'b0;
            end
            FETCH: begin
                if (redirect) begin
                    if_id_instr_d    = 32'd0;
                    if_id_pc_plus4_d = 32'd0;
                    if_id_valid_d    = 1'b0;
                    if (imem_ready) begin
                        pc_d = target;
                    end else begin
                        // Keep imem_addr stable until the outstanding read lands.
                        redirect_pc_d = target;
                        state_d       = DISCARD;
                    end
                end else if (stall) begin
                    // Hold everything; returned data is re-requested next cycle.
                end else if (imem_ready) begin
                    pc_d             = pc_plus4;
                    if_id_instr_d    = imem_rdata;
                    if_id_pc_plus4_d = pc_plus4;
                    if_id_valid_d    = 1'b1;
                end else begin
                    if_id_instr_d    = 32'd0;
                    if_id_pc_plus4_d = 32'd0;
                    if_id_valid_d    = 1'b0;
                end
            end
            DISCARD: begin
                if_id_instr_d    = 32'd0;
                if_id_pc_plus4_d = 32'd0;
                if_id_valid_d    = 1'b0;
                redirect_pc_d    = discard_pc;
                if (imem_ready) begin
                    pc_d    = discard_pc;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d          = BOOT;
                if_id_instr_d    = 32'd0;
                if_id_pc_plus4_d = 32'd0;
                if_id_valid_d    = 1'b0;
            end
        endcase

        // Flush wins over stall for IF/ID only; PC behaviour is unaffected.
        if (flush) begin
            if_id_instr_d    = 32'd0;
            if_id_pc_plus4_d = 32'd0;
            if_id_valid_d    = 1'b0;
        end

        imem_req_d = (state_d != BOOT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= BOOT;
            pc_q             <= RESET_PC;
            redirect_pc_q    <= RESET_PC;
            imem_req_q       <= 1'b0;
            if_id_instr_q    <= 32'd0;
            if_id_pc_plus4_q <= 32'd0;
            if_id_valid_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            redirect_pc_q    <= redirect_pc_d;
            imem_req_q       <= imem_req_d;
            if_id_instr_q    <= if_id_instr_d;
            if_id_pc_plus4_q <= if_id_pc_plus4_d;
            if_id_valid_q    <= if_id_valid_d;
        end
    end

    assign imem_req       = imem_req_q;
    assign imem_addr      = pc_q;
    assign pc             = pc_q;
    assign if_id_instr    = if_id_instr_q;
    assign if_id_pc_plus4 = if_id_pc_plus4_q;
    assign if_id_valid    = if_id_valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, flush, branch_taken, jump;
    logic [31:0] branch_target, jump_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc, if_id_instr, if_id_pc_plus4;
    logic        if_id_valid;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];
    logic [63:0] last_seen = 64'd0;
    logic        hold_edge = 1'b0;

    always #5 clk = ~clk;

    if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .pc(pc), .if_id_instr(if_id_instr),
        .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid)
    );

    // Address-tagged memory contents.
    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign imem_rdata = word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] addr, input logic [31:0] p4);
        exp_q.push_back({word(addr), p4});
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // IF/ID is expected to hold its value after an edge that saw a plain stall.
    always @(posedge clk) hold_edge = stall & ~flush & ~jump & ~branch_taken;

    // Scoreboard monitor: every valid IF/ID word must match the next expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && if_id_valid === 1'b1) begin
            if (hold_edge) begin
                checks++;
                if ({if_id_instr, if_id_pc_plus4} !== last_seen) begin
                    errors++;
                    $display("FAIL sb_hold: got %h expected %h", {if_id_instr, if_id_pc_plus4}, last_seen);
                end
            end else if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got %h expected none", {if_id_instr, if_id_pc_plus4});
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                checks++;
                if ({if_id_instr, if_id_pc_plus4} !== e) begin
                    errors++;
                    $display("FAIL sb_word: got %h expected %h", {if_id_instr, if_id_pc_plus4}, e);
                end
                last_seen = {if_id_instr, if_id_pc_plus4};
            end
        end
    end

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        branch_taken = 1'b0; jump = 1'b0;
        branch_target = 32'd0; jump_target = 32'd0;
        imem_ready = 1'b1;

        // Reset values
        #3;
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_instr", if_id_instr, 32'd0);
        chk("rst_p4", if_id_pc_plus4, 32'd0);
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);

        @(negedge clk); #2;
        reset = 1'b1;
        chk("boot_req", {31'd0, imem_req}, 32'd0);
        step();  // BOOT -> FETCH
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        chk("boot_bubble", {31'd0, if_id_valid}, 32'd0);

        // Sequential fetch 0,4,8,C
        push(32'h0, 32'h4); push(32'h4, 32'h8); push(32'h8, 32'hC); push(32'hC, 32'h10);
        for (int i = 0; i < 4; i++) step();
        chk("seq_pc", pc, 32'h10);

        // Memory not ready for 3 cycles at 0x10
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait_pc", pc, 32'h10);
            chk("wait_addr", imem_addr, 32'h10);
            chk("wait_valid", {31'd0, if_id_valid}, 32'd0);
        end
        imem_ready = 1'b1;
        push(32'h10, 32'h14); push(32'h14, 32'h18); push(32'h18, 32'h1C); push(32'h1C, 32'h20);
        for (int i = 0; i < 4; i++) step();
        chk("after_wait_pc", pc, 32'h20);

        // Stall 2 cycles at 0x20
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stall_pc", pc, 32'h20);
            chk("stall_instr", if_id_instr, word(32'h1C));
            chk("stall_p4", if_id_pc_plus4, 32'h20);
            chk("stall_valid", {31'd0, if_id_valid}, 32'd1);
        end
        stall = 1'b0;
        push(32'h20, 32'h24);
        step();
        chk("post_stall_pc", pc, 32'h24);

        // Branch to 0x103 while memory busy -> discard path
        imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h103;
        step();
        branch_taken = 1'b0;
        chk("disc_pc_hold", pc, 32'h24);
        chk("disc_valid", {31'd0, if_id_valid}, 32'd0);
        step();
        chk("disc_addr", imem_addr, 32'h24);
        imem_ready = 1'b1;
        step();
        chk("disc_drop_valid", {31'd0, if_id_valid}, 32'd0);
        chk("disc_new_pc", pc, 32'h100);
        push(32'h100, 32'h104);
        step();
        chk("br_pc", pc, 32'h104);

        // Jump beats branch and stall
        jump = 1'b1; jump_target = 32'h200;
        branch_taken = 1'b1; branch_target = 32'h300; stall = 1'b1;
        step();
        jump = 1'b0; branch_taken = 1'b0; stall = 1'b0;
        chk("jmp_pc", pc, 32'h200);
        chk("jmp_bubble", {31'd0, if_id_valid}, 32'd0);
        push(32'h200, 32'h204);
        step();

        // Flush: bubble while pc advances; flush+stall: pc holds, bubble
        flush = 1'b1;
        step();
        chk("flush_pc", pc, 32'h208);
        chk("flush_valid", {31'd0, if_id_valid}, 32'd0);
        stall = 1'b1;
        step();
        chk("flush_stall_pc", pc, 32'h208);
        chk("flush_stall_valid", {31'd0, if_id_valid}, 32'd0);
        flush = 1'b0; stall = 1'b0;

        // Reset pulsed mid-DISCARD
        imem_ready = 1'b0; jump = 1'b1; jump_target = 32'h400;
        step();
        jump = 1'b0;
        reset = 1'b0;
        #1;
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        chk("mid_rst_valid", {31'd0, if_id_valid}, 32'd0);
        imem_ready = 1'b1;
        step();
        @(negedge clk); #2;
        reset = 1'b1;
        step();
        chk("re_boot_valid", {31'd0, if_id_valid}, 32'd0);
        chk("re_boot_pc", pc, 32'h0);
        push(32'h0, 32'h4);
        step();

        // Wrap at 0xFFFF_FFFC
        jump = 1'b1; jump_target = 32'hFFFF_FFFF;
        step();
        jump = 1'b0;
        chk("wrap_start_pc", pc, 32'hFFFF_FFFC);
        push(32'hFFFF_FFFC, 32'h0);
        step();
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_p4", if_id_pc_plus4, 32'h0);
        imem_ready = 1'b0;
        step();
        step();

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset; bits [1:0] SHALL be 00.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-004 stall  input  1  hazard unit hold; PC and IF/ID register keep their values.
REQ-005 flush  input  1  squash IF/ID register to a bubble.
REQ-006 branch_taken  input  1  branch resolved taken in ID.
REQ-007 branch_target  input  32  branch destination address.
REQ-008 jump  input  1  jump resolved in ID.
REQ-009 jump_target  input  32  jump destination address.
REQ-010 imem_req  output  1  instruction memory read request.
REQ-011 imem_addr  output  32  word-aligned fetch address.
REQ-012 imem_ready  input  1  imem_rdata valid for imem_addr this cycle.
REQ-013 imem_rdata  input  32  fetched instruction word.
REQ-014 pc  output  32  current fetch PC.
REQ-015 if_id_instr  output  32  registered instruction to decode.
REQ-016 if_id_pc_plus4  output  32  registered PC+4 of that instruction.
REQ-017 if_id_valid  output  1  1 = if_id_instr is a real instruction, 0 = bubble.

Function
REQ-018 FSM states SHALL be BOOT, FETCH, DISCARD; BOOT -> FETCH unconditionally after one cycle.
REQ-019 In BOOT, imem_req SHALL be 0 and IF/ID SHALL load a bubble (instr 0, pc_plus4 0, valid 0).
REQ-020 In FETCH and DISCARD, imem_req SHALL be 1 and imem_addr SHALL equal pc.
REQ-021 Redirect = jump | branch_taken; target SHALL be jump_target if jump, else branch_target, with bits [1:0] forced to 00.
REQ-022 Priority per cycle SHALL be: redirect > stall > normal fetch.
REQ-023 FETCH, no redirect, no stall, imem_ready=1: pc <= pc+4 (mod 2^32, 0xFFFF_FFFC wraps to 0), IF/ID <= {imem_rdata, pc+4, valid 1}; fetch-to-IF/ID latency is 1 cycle.
REQ-024 FETCH, no redirect, no stall, imem_ready=0: pc holds, IF/ID <= bubble.
REQ-025 FETCH, stall, no redirect: pc and IF/ID hold, any imem_rdata is dropped, same address is re-requested.
REQ-026 FETCH, redirect, imem_ready=1: pc <= target, IF/ID <= bubble, stay FETCH, imem_rdata dropped.
REQ-027 FETCH, redirect, imem_ready=0: internal redirect_pc <= target, pc holds (imem_addr stable while request pending), IF/ID <= bubble, go DISCARD.
REQ-028 DISCARD: IF/ID <= bubble each cycle; a further redirect SHALL overwrite redirect_pc (latest wins); on imem_ready=1 the data SHALL be dropped, pc <= redirect_pc (or the new target if redirect same cycle), go FETCH.
REQ-029 flush SHALL force IF/ID <= bubble in any state, overriding stall for the IF/ID register only; pc follows REQ-023..028.
REQ-030 if_id_valid SHALL never be 1 for a word fetched from a squashed/abandoned address.

Reset
REQ-031 reset=0 SHALL immediately, without clock, set pc=RESET_PC, redirect_pc=RESET_PC, state=BOOT, imem_req=0, if_id_instr=0, if_id_pc_plus4=0, if_id_valid=0.
REQ-032 Reset asserted mid-wait or in DISCARD SHALL abandon the pending request; no stale data reaches IF/ID after release.
REQ-033 First imem_req=1 SHALL occur in the second rising edge's cycle after reset release (BOOT lasts exactly one cycle).

Verification
REQ-034 Reset release, imem_ready=1 always, imem_rdata=addr-based pattern -> pc 0,4,8,...; IF/ID at cycle n+1 holds word of addr 4n with pc_plus4 4n+4, valid 1.
REQ-035 imem_ready=0 for 3 cycles at pc=0x10 -> pc holds 0x10, if_id_valid 0 for 3 cycles, then word@0x10 with pc_plus4 0x14.
REQ-036 stall=1 for 2 cycles at pc=0x20 -> pc and IF/ID unchanged both cycles; after release word@0x20 fetched normally.
REQ-037 branch_taken=1, target 0x103, while imem_ready=0 -> DISCARD; next ready data dropped; pc becomes 0x100; first valid IF/ID instr is word@0x100.
REQ-038 jump=1 (0x200) and branch_taken=1 (0x300) with stall=1 same cycle -> pc=0x200 next cycle, IF/ID bubble.
REQ-039 reset pulsed low mid-DISCARD, and pc=0xFFFF_FFFC with ready -> outputs immediately at reset values; wrap case pc becomes 0x0000_0000, pc_plus4 0.
